multicycle_control_unit: RTL

//  Moore FSM control for the multicycle RV32I core (shared instr/data memory, IR/OldPC/A/B/Data/ALUOut regs).

---
 rtl/multicycle_control_unit.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM that sequences fetch, decode,
// execute, memory access and writeback over a shared instruction/data memory.
// State encoding, visible on state_o:
//   0 FETCH   1 DECODE  2 MEMADR  3 MEMREAD  4 MEMWB   5 MEMWRITE 6 EXECR
//   7 EXECI   8 ALUWB   9 BRANCH 10 JUMP    11 JALR   12 LINK    13 LUI   14 TRAP
//
// Memory handshake: in FETCH, MEMREAD and MEMWRITE the request (mem_read or
// mem_write with adr_src) is held steady every cycle the state is occupied.
// A transfer completes on the first cycle mem_ready is high; only on that
// cycle are the dependent enables (ir_write/pc_write in FETCH) asserted and
// only then does the FSM advance. With MEM_HANDSHAKE=0, mem_ready is treated
// as permanently high.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W    = 4,
  parameter int MEM_HANDSHAKE = 1,
  parameter int TRAP_STICKY   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7,
  input  logic                  eq,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  adr_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  pc_lsb_clear,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic                  illegal_instr,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_OR    = 4'b1011;
  localparam logic [3:0] ALU_AND   = 4'b1100;
  localparam logic [3:0] ALU_SLT   = 4'b1110;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;
  localparam logic [3:0] ALU_PASSB = 4'b0100;

  state_t     state;
  state_t     decode_next;
  logic       ready;
  logic       taken;
  logic [3:0] exec_alu;
  logic [3:0] alu4;

  assign ready   = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
  assign state_o = state;
  assign alu_ctrl = ALU_CTRL_W'(alu4);

  // Classify the instruction in IR; unsupported opcodes or funct3 values go to TRAP.
  always_comb begin
    decode_next = S_TRAP;
    case (opcode)
      OP_LOAD: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: decode_next = S_MEMADR;
          default:                                decode_next = S_TRAP;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'b000, 3'b001, 3'b010: decode_next = S_MEMADR;
          default:                decode_next = S_TRAP;
        endcase
      end
      OP_R:     decode_next = S_EXECR;
      OP_I:     decode_next = S_EXECI;
      OP_B: begin
        case (funct3)
          3'b010, 3'b011: decode_next = S_TRAP;
          default:        decode_next = S_BRANCH;
        endcase
      end
      OP_JAL:   decode_next = S_JUMP;
      OP_JALR:  decode_next = S_JALR;
      OP_LUI:   decode_next = S_LUI;
      OP_AUIPC: decode_next = S_ALUWB;
      default:  decode_next = S_TRAP;
    endcase
  end

  // Branch condition from the ALU flags of A-B; funct3 bit 0 inverts the sense.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // ALU operation for EXECR/EXECI; IR[30] means SUB only for R-type add, SRA for shifts right.
  always_comb begin
    exec_alu = ALU_ADD;
    case (funct3)
      3'b000:  exec_alu = (state == S_EXECR && funct7) ? ALU_SUB : ALU_ADD;
      3'b001:  exec_alu = ALU_SLL;
      3'b010:  exec_alu = ALU_SLT;
      3'b011:  exec_alu = ALU_SLTU;
      3'b100:  exec_alu = ALU_XOR;
      3'b101:  exec_alu = funct7 ? ALU_SRA : ALU_SRL;
      3'b110:  exec_alu = ALU_OR;
      default: exec_alu = ALU_AND;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_LUI, OP_AUIPC: imm_src = 3'b001;
      OP_STORE:         imm_src = 3'b010;
      OP_B:             imm_src = 3'b011;
      OP_JAL:           imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
  end

  // State register: advance through the instruction, holding on memory waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next;
        S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_LINK;
        S_JALR:     state <= S_LINK;
        S_LINK:     state <= S_FETCH;
        S_LUI:      state <= S_FETCH;
        S_TRAP:     if (TRAP_STICKY == 0) state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; reset suppresses every write/read enable.
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    pc_lsb_clear  = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu4          = ALU_ADD;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = ready;
        pc_write   = ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu4      = exec_alu;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu4      = exec_alu;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu4      = ALU_SUB;
        pc_write  = taken;
      end
      S_JUMP: pc_write = 1'b1;
      S_JALR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        result_src   = 2'b10;
        pc_write     = 1'b1;
        pc_lsb_clear = 1'b1;
      end
      S_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_b  = 2'b01;
        alu4       = ALU_PASSB;
        result_src = 2'b10;
        reg_write  = 1'b1;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: illegal_instr = 1'b0;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
    end
  end

endmodule
